periph_bus: RTL

- Parametrised peripheral interconnect between the processor data port and N memory-mapped peripherals in the 0x2xxx_xxxx region.
- Generalises the fixed two-peripheral combinational decode into a registered request/acknowledge bus.
- Supports a configurable slot count, per-slot wait states, a timeout with bus-error response, and error-status counters.
- Sits between the processor and the display, UART and future peripherals; memory accesses bypass it.

---
 rtl/periph_bus_pkg.sv | 23 ++
 rtl/bus_timer.sv | 41 ++++
 rtl/periph_bus.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/periph_bus_pkg.sv
// ---------------------------------------------------------------------------
// periph_bus_pkg : shared types and address-map constants for periph_bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0]  REGION_PERIPH = 4'h2;
  localparam logic [31:0] SLOT_SPAN     = 32'h1000;

  localparam int unsigned SLOT_DISPLAY = 1;
  localparam int unsigned SLOT_UART    = 2;

endpackage

`default_nettype wire

// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer : clearable 16-bit up-counter with terminal-count flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == TIMEOUT[15:0]);

endmodule

`default_nettype wire

// File: rtl/periph_bus.sv
// ---------------------------------------------------------------------------
// periph_bus : registered request/acknowledge interconnect to N peripheral slots
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_BITS = 4,
  parameter logic [3:0]  REGION    = REGION_PERIPH,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic                   cpu_req_i,
  input  logic                   cpu_we_i,
  input  logic [31:0]            cpu_addr_i,
  input  logic [31:0]            cpu_wdata_i,
  input  logic [3:0]             cpu_wmask_i,
  output logic [31:0]            cpu_rdata_o,
  output logic                   cpu_ack_o,
  output logic                   cpu_err_o,
  output logic                   busy_o,
  output logic [NUM_SLOTS-1:0]   p_sel_o,
  output logic                   p_we_o,
  output logic [11:0]            p_addr_o,
  output logic [31:0]            p_wdata_o,
  output logic [3:0]             p_wmask_o,
  input  logic [32*NUM_SLOTS-1:0] p_rdata_i,
  input  logic [NUM_SLOTS-1:0]   p_ack_i,
  output logic [7:0]             err_count_o,
  output logic [31:0]            err_addr_o
);

  localparam int unsigned OFFS_BITS = $clog2(SLOT_SPAN);

  state_e                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   sel_q, sel_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wmask_q, wmask_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [31:0]            err_addr_q, err_addr_d;

  logic [SLOT_BITS-1:0]   w_slot;
  logic [27-OFFS_BITS:0]  w_upper;
  logic                   w_slot_ok;
  logic [NUM_SLOTS-1:0]   w_sel_dec;
  logic [31:0]            w_slot_rdata;
  logic                   w_ack;
  logic                   w_timeout;
  logic                   w_err_evt;
  logic [31:0]            w_err_addr;

  assign w_slot    = cpu_addr_i[OFFS_BITS +: SLOT_BITS];
  // Address bits above the slot field must be zero for a legal slot.
  assign w_upper   = cpu_addr_i[27:OFFS_BITS] >> SLOT_BITS;
  assign w_slot_ok = ({1'b0, w_slot} < NUM_SLOTS[SLOT_BITS:0]) && (w_upper == '0);
  assign w_ack     = |(p_ack_i & sel_q);

  always_comb begin
    w_sel_dec    = '0;
    w_slot_rdata = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_slot == SLOT_BITS'(s)) w_sel_dec[s] = 1'b1;
      if (sel_q[s]) w_slot_rdata = p_rdata_i[32*s +: 32];
    end
  end

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clear_i  (state_q != ST_ACCESS),
    .enable_i (state_q == ST_ACCESS),
    .done_o   (w_timeout)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    w_err_evt  = 1'b0;
    w_err_addr = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && (cpu_addr_i[31:28] == REGION)) begin
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wmask_d = cpu_wmask_i;
          if (w_slot_ok) begin
            sel_d   = w_sel_dec;
            state_d = ST_ACCESS;
          end else begin
            rdata_d    = ERR_RDATA;
            err_d      = 1'b1;
            w_err_evt  = 1'b1;
            w_err_addr = cpu_addr_i;
            state_d    = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // A slot ack on the terminal-count cycle takes priority over the timeout.
        if (w_ack) begin
          sel_d   = '0;
          rdata_d = we_q ? 32'h0 : w_slot_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (w_timeout) begin
          sel_d     = '0;
          rdata_d   = ERR_RDATA;
          err_d     = 1'b1;
          w_err_evt = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_err_evt) begin
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      err_addr_d = w_err_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign cpu_ack_o   = (state_q == ST_RESP);
  assign cpu_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign p_sel_o     = sel_q;
  assign p_we_o      = we_q;
  assign p_addr_o    = addr_q[11:0];
  assign p_wdata_o   = wdata_q;
  assign p_wmask_o   = wmask_q;
  assign err_count_o = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule

`default_nettype wire
